led_pwm_ctrl: RTL

Parametrised multi-channel LED driver, successor to the free-running LED blink counter. It drives CHANNELS active-low LED outputs. Each channel has its own mode (off, on, PWM, blink) and an 8-bit-class duty value. All channels share one prescaler, one PWM counter and one blink counter, and configuration updates are glitch-free at PWM period boundaries. It sits between the top level's slow clock domain and the LED_R/G/B pins.

---
 rtl/led_pwm_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/led_pwm_ctrl.sv
// Multi-channel active-low LED driver: shared prescaler/PWM/blink counters, per-channel
// shadow/active config swapped at PWM period boundaries. Define LED_BREATHE_EN to turn mode 3 into BREATHE.
module led_pwm_ctrl #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned PRESCALE   = 1,
   parameter int unsigned BLINK_BITS = 4,
   localparam int unsigned CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned PRE_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cfg_we,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [CHANNELS-1:0] pending,
   output logic                period_start,
   output logic [CHANNELS-1:0] led_n
);

   localparam logic [1:0] ModeOff   = 2'd0;
   localparam logic [1:0] ModeOn    = 2'd1;
   localparam logic [1:0] ModePwm   = 2'd2;
   localparam logic [1:0] ModeBlink = 2'd3;

   logic [PRE_W-1:0]      pre_cnt_q, pre_cnt_d;
   logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_BITS-1:0] blink_cnt_q, blink_cnt_d;
   logic                  tick, boundary, blink_on;

   logic [1:0]            shadow_mode_q [CHANNELS];
   logic [1:0]            shadow_mode_d [CHANNELS];
   logic [PWM_BITS-1:0]   shadow_duty_q [CHANNELS];
   logic [PWM_BITS-1:0]   shadow_duty_d [CHANNELS];
   logic [1:0]            active_mode_q [CHANNELS];
   logic [1:0]            active_mode_d [CHANNELS];
   logic [PWM_BITS-1:0]   active_duty_q [CHANNELS];
   logic [PWM_BITS-1:0]   active_duty_d [CHANNELS];
   logic [CHANNELS-1:0]   pending_d;
   logic [CHANNELS-1:0]   on_d;

   assign tick        = (pre_cnt_q == PRE_W'(PRESCALE - 1));
   assign pre_cnt_d   = tick ? '0 : pre_cnt_q + 1'b1;
   assign pwm_cnt_d   = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
   assign boundary    = tick && (pwm_cnt_q == '1);
   assign blink_cnt_d = boundary ? blink_cnt_q + 1'b1 : blink_cnt_q;
   // LEDs are evaluated against next-cycle counters so period start uses the new settings
   assign blink_on    = ~blink_cnt_d[BLINK_BITS-1];

`ifdef LED_BREATHE_EN
   localparam logic [PWM_BITS-1:0] DutyMax     = '1;
   localparam logic [PWM_BITS-1:0] DutyNearMax = DutyMax - 1'b1;
   localparam logic [PWM_BITS-1:0] DutyOne     = PWM_BITS'(1);

   logic [PWM_BITS-1:0] breathe_duty_q, breathe_duty_d;
   logic                dir_up_q, dir_up_d;

   always_comb begin
      breathe_duty_d = breathe_duty_q;
      dir_up_d       = dir_up_q;
      if (boundary) begin
         if (dir_up_q) begin
            breathe_duty_d = breathe_duty_q + 1'b1;
            if (breathe_duty_q == DutyNearMax) dir_up_d = 1'b0;
         end else begin
            breathe_duty_d = breathe_duty_q - 1'b1;
            if (breathe_duty_q == DutyOne) dir_up_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         breathe_duty_q <= '0;
         dir_up_q       <= 1'b1;
      end else begin
         breathe_duty_q <= breathe_duty_d;
         dir_up_q       <= dir_up_d;
      end
   end
`endif

   always_comb begin
      pending_d = pending;
      on_d      = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         shadow_mode_d[i] = shadow_mode_q[i];
         shadow_duty_d[i] = shadow_duty_q[i];
         active_mode_d[i] = active_mode_q[i];
         active_duty_d[i] = active_duty_q[i];
         if (boundary) begin
            if (pending[i]) begin
               active_mode_d[i] = shadow_mode_q[i];
               active_duty_d[i] = shadow_duty_q[i];
            end
            pending_d[i] = 1'b0;
         end
         // Out-of-range cfg_ch matches no channel, so such writes fall through untouched
         if (cfg_we && (cfg_ch == CH_W'(i))) begin
            shadow_mode_d[i] = cfg_mode;
            shadow_duty_d[i] = cfg_duty;
            if (boundary) begin
               active_mode_d[i] = cfg_mode;
               active_duty_d[i] = cfg_duty;
            end else begin
               pending_d[i] = 1'b1;
            end
         end
         unique case (active_mode_d[i])
            ModeOff:   on_d[i] = 1'b0;
            ModeOn:    on_d[i] = 1'b1;
            ModePwm:   on_d[i] = (pwm_cnt_d < active_duty_d[i]);
`ifdef LED_BREATHE_EN
            ModeBlink: on_d[i] = (pwm_cnt_d < breathe_duty_d);
`else
            ModeBlink: on_d[i] = (pwm_cnt_d < active_duty_d[i]) && blink_on;
`endif
            default:   on_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pre_cnt_q    <= '0;
         pwm_cnt_q    <= '0;
         blink_cnt_q  <= '0;
         pending      <= '0;
         period_start <= 1'b0;
         led_n        <= '1;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_mode_q[i] <= ModeOff;
            shadow_duty_q[i] <= '0;
            active_mode_q[i] <= ModeOff;
            active_duty_q[i] <= '0;
         end
      end else begin
         pre_cnt_q    <= pre_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         blink_cnt_q  <= blink_cnt_d;
         pending      <= pending_d;
         period_start <= boundary;
         led_n        <= ~on_d;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_mode_q[i] <= shadow_mode_d[i];
            shadow_duty_q[i] <= shadow_duty_d[i];
            active_mode_q[i] <= active_mode_d[i];
            active_duty_q[i] <= active_duty_d[i];
         end
      end
   end

endmodule
